// File: rtl/ahb_lite_master.sv
// Single AHB-Lite master: turns a command/write-data stream into pipelined AHB-Lite
// transfers with fixed-length INCR/WRAP bursts, BUSY insertion on late write data and ERROR abort.
module ahb_lite_master #(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [2:0]  cmd_burst,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  input  logic [31:0] wdata,
  output logic        rdata_valid,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [31:0] HRDATA
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ADDR  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  logic [1:0]  state_q, state_d;
  logic [4:0]  beats_q, beats_d;
  logic [4:0]  beats_left_q, beats_left_d;
  logic [4:0]  beats_req_q, beats_req_d;
  logic [31:0] addr_mask_q, addr_mask_d;
  logic        buf_full_q, buf_full_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic        dphase_q, dphase_d;
  logic [1:0]  htrans_q, htrans_d;
  logic [31:0] haddr_q, haddr_d;
  logic        hwrite_q, hwrite_d;
  logic [2:0]  hsize_q, hsize_d;
  logic [2:0]  hburst_q, hburst_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        addr_done;
  logic        data_done;
  logic        buf_free;
  logic        wfire;
  logic        issue_ok;
  logic [4:0]  left_n;
  logic [4:0]  cmd_beats;
  logic        cmd_wrap;
  logic [31:0] size_mask;
  logic [31:0] next_addr;

  function automatic logic [4:0] burst_beats(input logic [2:0] burst);
    case (burst)
      3'b010, 3'b011: burst_beats = 5'd4;
      3'b100, 3'b101: burst_beats = 5'd8;
      3'b110, 3'b111: burst_beats = 5'd16;
      default:        burst_beats = 5'd1;
    endcase
  endfunction

  assign cmd_beats = burst_beats(cmd_burst);
  assign cmd_wrap  = (cmd_burst == 3'b010) || (cmd_burst == 3'b100) || (cmd_burst == 3'b110);
  assign size_mask = (32'd1 << cmd_size) - 32'd1;

  // INCR keeps an all-ones mask so the wrap formula degenerates to a plain add.
  assign next_addr = (haddr_q & ~addr_mask_q) | ((haddr_q + (32'd1 << hsize_q)) & addr_mask_q);

  assign addr_done = HREADY & htrans_q[1];
  assign data_done = HREADY & dphase_q;
  assign buf_free  = ~buf_full_q | (addr_done & hwrite_q);
  assign cmd_ready = (state_q == ST_IDLE);
  assign wfire     = wdata_valid & wdata_ready;

  // Write data may be taken alongside the command itself so the first NONSEQ is not delayed.
  always_comb begin
    wdata_ready = 1'b0;
    case (state_q)
      ST_IDLE: wdata_ready = cmd_valid & cmd_write;
      ST_ADDR: wdata_ready = hwrite_q & buf_free & (beats_req_q < beats_q)
                             & ~(dphase_q & HRESP);
      default: wdata_ready = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every next-state value starts from its current value (or a pulse default) so no
    // path through this block leaves a signal unassigned and infers a latch.
    state_d       = state_q;
    beats_d       = beats_q;
    beats_left_d  = beats_left_q;
    beats_req_d   = beats_req_q;
    addr_mask_d   = addr_mask_q;
    buf_full_d    = buf_full_q;
    buf_data_d    = buf_data_q;
    htrans_d      = htrans_q;
    haddr_d       = haddr_q;
    hwrite_d      = hwrite_q;
    hsize_d       = hsize_q;
    hburst_d      = hburst_q;
    hwdata_d      = hwdata_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    done_d        = 1'b0;
    err_d         = 1'b0;
    dphase_d      = HREADY ? htrans_q[1] : dphase_q;
    left_n        = beats_left_q;
    issue_ok      = 1'b0;

    if (data_done && !HRESP && !hwrite_q) begin
      rdata_d       = HRDATA;
      rdata_valid_d = 1'b1;
    end

    if (addr_done) begin
      haddr_d      = next_addr;
      left_n       = beats_left_q - 5'd1;
      beats_left_d = left_n;
      if (hwrite_q) begin
        hwdata_d   = buf_data_q;
        buf_full_d = 1'b0;
      end
    end

    if (wfire) begin
      buf_full_d  = 1'b1;
      buf_data_d  = wdata;
      beats_req_d = beats_req_q + 5'd1;
    end

    issue_ok = ~hwrite_q | buf_full_d;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          hwrite_d     = cmd_write;
          hsize_d      = cmd_size;
          hburst_d     = (cmd_burst == 3'b001) ? 3'b000 : cmd_burst;
          beats_d      = cmd_beats;
          beats_left_d = cmd_beats;
          beats_req_d  = {4'd0, wfire};
          addr_mask_d  = cmd_wrap ? (({27'd0, cmd_beats} << cmd_size) - 32'd1) : 32'hFFFF_FFFF;
          haddr_d      = cmd_addr & ~size_mask;
          htrans_d     = (!cmd_write || wfire) ? TR_NONSEQ : TR_IDLE;
          state_d      = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (HREADY) begin
          if (left_n == 5'd0) begin
            htrans_d = TR_IDLE;
            state_d  = ST_DRAIN;
          end else if (issue_ok) begin
            htrans_d = (left_n == beats_q) ? TR_NONSEQ : TR_SEQ;
          end else begin
            htrans_d = (left_n == beats_q) ? TR_IDLE : TR_BUSY;
          end
        end
      end
      ST_DRAIN: begin
        if (data_done && !HRESP) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (HREADY) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // First ERROR cycle cancels the rest of the burst; the second one ends the command.
    if (dphase_q && HRESP) begin
      htrans_d     = TR_IDLE;
      beats_left_d = 5'd0;
      buf_full_d   = 1'b0;
      if (HREADY) begin
        done_d   = 1'b1;
        err_d    = 1'b1;
        dphase_d = 1'b0;
        state_d  = ST_IDLE;
      end else begin
        state_d  = ST_ERR;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q       <= ST_IDLE;
      beats_q       <= 5'd0;
      beats_left_q  <= 5'd0;
      beats_req_q   <= 5'd0;
      addr_mask_q   <= 32'd0;
      buf_full_q    <= 1'b0;
      buf_data_q    <= 32'd0;
      dphase_q      <= 1'b0;
      htrans_q      <= TR_IDLE;
      haddr_q       <= 32'd0;
      hwrite_q      <= 1'b0;
      hsize_q       <= 3'd0;
      hburst_q      <= 3'd0;
      hwdata_q      <= 32'd0;
      rdata_q       <= 32'd0;
      rdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop samples the
      // pre-edge values computed above, independent of statement order.
      state_q       <= state_d;
      beats_q       <= beats_d;
      beats_left_q  <= beats_left_d;
      beats_req_q   <= beats_req_d;
      addr_mask_q   <= addr_mask_d;
      buf_full_q    <= buf_full_d;
      buf_data_q    <= buf_data_d;
      dphase_q      <= dphase_d;
      htrans_q      <= htrans_d;
      haddr_q       <= haddr_d;
      hwrite_q      <= hwrite_d;
      hsize_q       <= hsize_d;
      hburst_q      <= hburst_d;
      hwdata_q      <= hwdata_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign HTRANS      = htrans_q;
  assign HADDR       = haddr_q;
  assign HWRITE      = hwrite_q;
  assign HSIZE       = hsize_q;
  assign HBURST      = hburst_q;
  assign HWDATA      = hwdata_q;
  assign HPROT       = HPROT_VAL;
  assign HMASTLOCK   = 1'b0;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: cycle-by-cycle vector table for the main transfers,
// plus a hand-written asynchronous-reset-mid-burst sequence.
module tb_ahb_lite_master;

  logic        HCLK;
  logic        HRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [2:0]  cmd_burst;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [31:0] wdata;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HRDATA;

  ahb_lite_master #(.HPROT_VAL(4'b0011)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata), .done(done), .err(err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        cv, cw;
    logic [31:0] ca;
    logic [2:0]  cs, cb;
    logic        wv;
    logic [31:0] wd;
    logic        hr, hs;
    logic [31:0] hrd;
    logic        e_cr, e_wr;
    logic [1:0]  e_ht;
    logic [31:0] e_ha, e_hw;
    logic        e_rv;
    logic [31:0] e_rd;
    logic        e_dn, e_er;
    logic [6:0]  e_ctrl;
  } vec_t;

  vec_t tv[$];
  int   checks = 0;
  int   errors = 0;

  localparam int I = 0, B = 1, N = 2, S = 3;
  localparam logic [6:0]  C_RD1  = 7'b0_010_000;
  localparam logic [6:0]  C_WR4  = 7'b1_010_011;
  localparam logic [6:0]  C_WRP4 = 7'b0_010_010;
  localparam logic [6:0]  C_RD8  = 7'b0_010_101;
  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] A1 = 32'hA000_0001, A2 = 32'hA000_0002;
  localparam logic [31:0] A3 = 32'hA000_0003, A4 = 32'hA000_0004;
  localparam logic [31:0] B1 = 32'hB000_0001, B2 = 32'hB000_0002;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] cv, cw, ca, cs, cb, wv, wd, hr, hs, hrd,
                     input logic [31:0] e_cr, e_wr, e_ht, e_ha, e_hw, e_rv, e_rd,
                     input logic [31:0] e_dn, e_er, e_ctrl);
    vec_t v;
    v.cv = cv[0]; v.cw = cw[0]; v.ca = ca; v.cs = cs[2:0]; v.cb = cb[2:0];
    v.wv = wv[0]; v.wd = wd; v.hr = hr[0]; v.hs = hs[0]; v.hrd = hrd;
    v.e_cr = e_cr[0]; v.e_wr = e_wr[0]; v.e_ht = e_ht[1:0]; v.e_ha = e_ha; v.e_hw = e_hw;
    v.e_rv = e_rv[0]; v.e_rd = e_rd; v.e_dn = e_dn[0]; v.e_er = e_er[0]; v.e_ctrl = e_ctrl[6:0];
    tv.push_back(v);
  endtask

  // Row with no new command offered.
  task automatic nxt(input logic [31:0] wv, wd, hr, hs, hrd,
                     input logic [31:0] e_cr, e_wr, e_ht, e_ha, e_hw, e_rv, e_rd,
                     input logic [31:0] e_dn, e_er, e_ctrl);
    add(0, 0, 0, 0, 0, wv, wd, hr, hs, hrd, e_cr, e_wr, e_ht, e_ha, e_hw, e_rv, e_rd,
        e_dn, e_er, e_ctrl);
  endtask

  task automatic drive(input vec_t v);
    cmd_valid = v.cv; cmd_write = v.cw; cmd_addr = v.ca; cmd_size = v.cs; cmd_burst = v.cb;
    wdata_valid = v.wv; wdata = v.wd; HREADY = v.hr; HRESP = v.hs; HRDATA = v.hrd;
  endtask

  initial begin
    bit got_done;

    // Single read 0x100, then back-to-back INCR4 write offered in the done cycle.
    add(1, 0, 'h100, 2, 0, 0, 0, 1, 0, 0,   1, 0, I, 'h0,   'h0, 0, 'h0, 0, 0, 0);
    nxt(0, 0, 1, 0, 0,                      0, 0, N, 'h100, 'h0, 0, 'h0, 0, 0, C_RD1);
    nxt(0, 0, 1, 0, DB,                     0, 0, I, 'h104, 'h0, 0, 'h0, 0, 0, 0);
    add(1, 1, 'h200, 2, 3, 1, 1, 1, 0, 0,   1, 1, I, 'h104, 'h0, 1, DB,  1, 0, 0);
    nxt(1, 2, 1, 0, 0,                      0, 1, N, 'h200, 'h0, 0, DB, 0, 0, C_WR4);
    nxt(1, 3, 1, 0, 0,                      0, 1, S, 'h204, 'h1, 0, DB, 0, 0, C_WR4);
    nxt(1, 4, 1, 0, 0,                      0, 1, S, 'h208, 'h2, 0, DB, 0, 0, C_WR4);
    nxt(0, 0, 1, 0, 0,                      0, 0, S, 'h20C, 'h3, 0, DB, 0, 0, C_WR4);
    nxt(0, 0, 1, 0, 0,                      0, 0, I, 'h210, 'h4, 0, DB, 0, 0, 0);
    nxt(0, 0, 1, 0, 0,                      1, 0, I, 'h210, 'h4, 0, DB, 1, 0, 0);
    // WRAP4 read at 0x38.
    add(1, 0, 'h38, 2, 2, 0, 0, 1, 0, 0,    1, 0, I, 'h210, 'h4, 0, DB, 0, 0, 0);
    nxt(0, 0, 1, 0, 0,                      0, 0, N, 'h38,  'h4, 0, DB, 0, 0, C_WRP4);
    nxt(0, 0, 1, 0, A1,                     0, 0, S, 'h3C,  'h4, 0, DB, 0, 0, C_WRP4);
    nxt(0, 0, 1, 0, A2,                     0, 0, S, 'h30,  'h4, 1, A1, 0, 0, C_WRP4);
    nxt(0, 0, 1, 0, A3,                     0, 0, S, 'h34,  'h4, 1, A2, 0, 0, C_WRP4);
    nxt(0, 0, 1, 0, A4,                     0, 0, I, 'h38,  'h4, 1, A3, 0, 0, 0);
    nxt(0, 0, 1, 0, 0,                      1, 0, I, 'h38,  'h4, 1, A4, 1, 0, 0);
    // INCR4 write with wdata_valid low for two cycles after beat 2.
    add(1, 1, 'h200, 2, 3, 1, 'h11, 1, 0, 0, 1, 1, I, 'h38, 'h4, 0, A4, 0, 0, 0);
    nxt(1, 'h22, 1, 0, 0,                   0, 1, N, 'h200, 'h4,  0, A4, 0, 0, C_WR4);
    nxt(0, 0, 1, 0, 0,                      0, 1, S, 'h204, 'h11, 0, A4, 0, 0, C_WR4);
    nxt(0, 0, 1, 0, 0,                      0, 1, B, 'h208, 'h22, 0, A4, 0, 0, C_WR4);
    nxt(1, 'h33, 1, 0, 0,                   0, 1, B, 'h208, 'h22, 0, A4, 0, 0, C_WR4);
    nxt(1, 'h44, 1, 0, 0,                   0, 1, S, 'h208, 'h22, 0, A4, 0, 0, C_WR4);
    nxt(0, 0, 1, 0, 0,                      0, 0, S, 'h20C, 'h33, 0, A4, 0, 0, C_WR4);
    nxt(0, 0, 1, 0, 0,                      0, 0, I, 'h210, 'h44, 0, A4, 0, 0, 0);
    nxt(0, 0, 1, 0, 0,                      1, 0, I, 'h210, 'h44, 0, A4, 1, 0, 0);
    // INCR8 read: two wait states on beat 1, ERROR on beat 3.
    add(1, 0, 'h400, 2, 5, 0, 0, 1, 0, 0,   1, 0, I, 'h210, 'h44, 0, A4, 0, 0, 0);
    nxt(0, 0, 1, 0, 0,                      0, 0, N, 'h400, 'h44, 0, A4, 0, 0, C_RD8);
    nxt(0, 0, 0, 0, 0,                      0, 0, S, 'h404, 'h44, 0, A4, 0, 0, C_RD8);
    nxt(0, 0, 0, 0, 0,                      0, 0, S, 'h404, 'h44, 0, A4, 0, 0, C_RD8);
    nxt(0, 0, 1, 0, B1,                     0, 0, S, 'h404, 'h44, 0, A4, 0, 0, C_RD8);
    nxt(0, 0, 1, 0, B2,                     0, 0, S, 'h408, 'h44, 1, B1, 0, 0, C_RD8);
    nxt(0, 0, 0, 1, 0,                      0, 0, S, 'h40C, 'h44, 1, B2, 0, 0, C_RD8);
    nxt(0, 0, 1, 1, 0,                      0, 0, I, 'h40C, 'h44, 0, B2, 0, 0, 0);
    nxt(0, 0, 1, 0, 0,                      1, 0, I, 'h40C, 'h44, 0, B2, 1, 1, 0);
    nxt(0, 0, 1, 0, 0,                      1, 0, I, 'h40C, 'h44, 0, B2, 0, 0, 0);

    HRESETn = 1'b0;
    drive(tv[0]);
    cmd_valid = 1'b0;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    #1;
    check("rst htrans", HTRANS, 0);
    check("rst haddr", HADDR, 0);
    check("rst ctrl", {HWRITE, HSIZE, HBURST}, 0);
    check("rst hwdata", HWDATA, 0);
    check("rst rdata", rdata, 0);
    check("rst pulses", {rdata_valid, done, err}, 0);
    check("rst cmd_ready", cmd_ready, 1);
    check("hprot", HPROT, 4'b0011);
    check("hmastlock", HMASTLOCK, 0);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge HCLK);
      drive(tv[i]);
      #1;
      check($sformatf("v%0d cmd_ready", i), cmd_ready, tv[i].e_cr);
      check($sformatf("v%0d wdata_ready", i), wdata_ready, tv[i].e_wr);
      check($sformatf("v%0d htrans", i), HTRANS, tv[i].e_ht);
      check($sformatf("v%0d haddr", i), HADDR, tv[i].e_ha);
      check($sformatf("v%0d hwdata", i), HWDATA, tv[i].e_hw);
      check($sformatf("v%0d rdata_valid", i), rdata_valid, tv[i].e_rv);
      check($sformatf("v%0d rdata", i), rdata, tv[i].e_rd);
      check($sformatf("v%0d done", i), done, tv[i].e_dn);
      check($sformatf("v%0d err", i), err, tv[i].e_er);
      if (tv[i].e_ht != 2'd0)
        check($sformatf("v%0d ctrl", i), {HWRITE, HSIZE, HBURST}, tv[i].e_ctrl);
    end

    // Asynchronous reset in the middle of an INCR16 read.
    @(negedge HCLK);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h800; cmd_size = 3'd2; cmd_burst = 3'b111;
    wdata_valid = 1'b0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h1234_5678;
    #1;
    check("r16 cmd_ready", cmd_ready, 1);
    @(negedge HCLK);
    cmd_valid = 1'b0;
    #1;
    check("r16 nonseq", {HTRANS, HADDR}, {2'b10, 32'h800});
    check("r16 hburst", HBURST, 3'b111);
    @(negedge HCLK);
    #1;
    check("r16 seq", {HTRANS, HADDR}, {2'b11, 32'h804});
    #1 HRESETn = 1'b0;
    #1;
    check("async htrans", HTRANS, 0);
    check("async haddr", HADDR, 0);
    check("async ctrl", {HWRITE, HSIZE, HBURST}, 0);
    check("async cmd_ready", cmd_ready, 1);
    @(negedge HCLK);
    #1;
    check("inrst pulses", {rdata_valid, done, err}, 0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    cmd_valid = 1'b1; cmd_addr = 32'h100; cmd_burst = 3'b000; HRDATA = 32'hCAFE_F00D;
    #1;
    check("post cmd_ready", cmd_ready, 1);
    check("post done", done, 0);
    got_done = 1'b0;
    for (int c = 0; c < 8 && !got_done; c++) begin
      @(negedge HCLK);
      cmd_valid = 1'b0;
      #1;
      if (done) begin
        got_done = 1'b1;
        check("post err", err, 0);
        check("post rdata_valid", rdata_valid, 1);
        check("post rdata", rdata, 32'hCAFE_F00D);
      end
    end
    check("post done seen", {31'd0, got_done}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_lite_master.md
Name: ahb_lite_master

Overview:
- Single AHB-Lite bus master that turns a simple command/data stream into AHB-Lite transfers. It drives the address/control/HWDATA inputs of the slave stage (ahb_slave) and consumes that stage's HREADYout, HRESP and HRDATA.
- Handles the pipelined address/data phases and fixed-length INCR/WRAP bursts.
- Inserts BUSY when write data is late.
- Aborts a burst on an ERROR response.

Parameters:
- HPROT_VAL, 4'b0011, constant driven on HPROT (non-cacheable, non-bufferable, privileged, data).

Ports:
- HCLK  input  1  bus clock; all state on rising edge.
- HRESETn  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  32  start byte address.
- cmd_size  input  3  HSIZE value; only 0..2 legal.
- cmd_burst  input  3  HBURST encoding; SINGLE, INCR4, WRAP4, INCR8, WRAP8, INCR16, WRAP16 legal; INCR(001) treated as SINGLE.
- wdata_valid  input  1  write beat data available.
- wdata_ready  output  1  write beat accepted on wdata_valid & wdata_ready.
- wdata  input  32  write beat data.
- rdata_valid  output  1  one-cycle pulse per good read beat.
- rdata  output  32  read beat data.
- done  output  1  one-cycle pulse when the command finishes.
- err  output  1  valid with done; 1 = ERROR received.
- HADDR  output  32  AHB address.
- HTRANS  output  2  AHB transfer type.
- HWRITE  output  1  AHB direction.
- HSIZE  output  3  AHB size.
- HBURST  output  3  AHB burst type.
- HPROT  output  4  AHB protection.
- HMASTLOCK  output  1  tied 0.
- HWDATA  output  32  write data.
- HREADY  input  1  from slave HREADYout.
- HRESP  input  1  0 = OKAY, 1 = ERROR.
- HRDATA  input  32  read data.

Behaviour:
- Reset values:
  - HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HBURST=0, HWDATA=0.
  - rdata=0, rdata_valid=0, done=0, err=0.
  - Write buffer empty; state IDLE.
  - HPROT=HPROT_VAL and HMASTLOCK=0 always.
- All AHB outputs are registered.
- States:
  - IDLE: cmd_ready=1, HTRANS=IDLE. On acceptance:
    - Latch command.
    - beats = 1/4/8/16 from cmd_burst.
    - Mask address low bits to HSIZE alignment.
    - Go to ADDR.
  - ADDR: address phases outstanding (beats_left>0).
  - DRAIN: last address accepted; waiting for the final data phase.
  - ERR: abort after the first ERROR cycle.
- Write buffer: one entry.
  - wdata_ready = write command active & buffer empty & beats_requested < beats.
  - Data is never requested beyond burst length.
- Address issue (ADDR state):
  - Issue the next beat when the command is a read, or when the write buffer is full or being filled this cycle.
  - First beat is NONSEQ, later beats SEQ.
  - If a write's next data is missing:
    - Mid-burst, drive BUSY with the next address held.
    - Before the first beat, stay IDLE.
- A beat's address phase completes on a clock edge with HREADY=1 and HTRANS NONSEQ/SEQ. At that edge:
  - The beat's write data moves from the buffer to HWDATA and is held through its data phase.
  - HADDR advances by 1<<HSIZE.
  - For WRAPn, the address wraps inside the (n << HSIZE)-byte aligned block; upper bits are unchanged.
- Latency: command accepted at edge T gives NONSEQ visible after edge T (cycle T+1) for reads or when write data is already buffered.
- An HREADY=0 wait state holds HADDR, HTRANS, control and HWDATA stable.
- Read data phase with HREADY=1 & HRESP=0: rdata<=HRDATA and rdata_valid pulses the next cycle. No backpressure.
- After the last address is accepted, HTRANS=IDLE. done pulses the cycle after the final data phase completes with err=0. Return to IDLE; cmd_ready is 1 in that same cycle.
- ERROR handling:
  - When HRESP=1 & HREADY=0 is seen during a data phase, HTRANS becomes IDLE at the next edge. Remaining beats are cancelled, the write buffer is flushed, and wdata_ready goes 0.
  - When HRESP=1 & HREADY=1 completes, done=1 and err=1 for one cycle. Go to IDLE.
  - An ERROR beat produces no rdata_valid.
- BUSY is never inserted on reads. No 1 KB boundary check: caller guarantees compliance.
- Reset asserted mid-burst: all state and outputs return to reset values immediately (asynchronous), with no done pulse.

Test Plan:
- Single read, addr 0x100, size 2, slave zero-wait, HRDATA 0xDEADBEEF:
  - NONSEQ at 0x100, then IDLE.
  - rdata_valid with 0xDEADBEEF.
  - done=1, err=0.
- INCR4 write, addr 0x200, size 2, data 1..4 supplied continuously:
  - HADDR 0x200/204/208/20C with NONSEQ,SEQ,SEQ,SEQ.
  - HWDATA 1..4 each one cycle after its address.
  - done after beat 4.
- WRAP4 read, addr 0x38, size 2: HADDR 0x38, 0x3C, 0x30, 0x34; four rdata_valid pulses.
- INCR4 write with wdata_valid dropped for 2 cycles after beat 2:
  - Two BUSY cycles with HADDR 0x208 held.
  - Then SEQ 0x208; all four data beats correct.
- INCR8 read with 2 wait states on beat 1: HADDR, HTRANS and control stay stable during the waits.
  - Slave returns ERROR on beat 3: HTRANS=IDLE in the second error cycle.
  - No further SEQ beats; rdata_valid only for beats 1–2; done=1 with err=1.
- HRESETn pulled low mid INCR16:
  - HTRANS=IDLE and HADDR=0 immediately.
  - After release, cmd_ready=1 and a new single read completes normally.
